fast_vram_sched: RTL and testbench
==================================

// Module: fast_vram_sched
// PURPOSE
// - Time-slot scheduler for the fast VRAM (upper 2K words: Y/shrink attributes and the active list).
// - Divides each 8-clock fast cycle into four 2-clock access slots.
// - Shares the slots between sprite Y-render reads, active-list reads, CPU access and Y-parse.
// - Drives the address-mux select, CWE_n and the per-consumer latch strobes; owns the parse index and active-list write counters.
// PARAMETERS
// - PARSE_LAST  380  last sprite index parsed per line (index range 0..PARSE_LAST)
// - ACTIVE_MAX   96  active-list capacity; ACTIVE_FULL asserts at this count
// PORTS
// - CLK_24M      in   1   master clock; every register updates on its rising edge
// - nRESET       in   1   asynchronous, active-low reset
// - NEW_LINE     in   1   1-clock pulse at line start; restarts parse and clears the active list
// - CPU_REQ      in   1   CPU access request; sampled only while CPU_BUSY=0
// - CPU_WR       in   1   1=write, 0=read; qualified by CPU_REQ
// - CPU_ADDR     in   11  CPU word address within the fast VRAM
// - CPU_WDATA    in   16  CPU write data
// - CPU_BUSY     out  1   high from request accept until the CPU access slot completes
// - CPU_RDATA    out  16  read data; held until the next CPU read completes
// - CPU_ACK      out  1   1-clock pulse when the CPU access completes
// - PARSE_MATCH  in   1   datapath: sprite just read is active on the next line (valid when PARSE_STB=1)
// - VRAM_DIN     in   16  fast VRAM data bus, read direction
// - VRAM_ADDR    out  11  address presented to the fast VRAM
// - VRAM_DOUT    out  16  write data
// - CWE_n        out  1   active-low write enable
// - SLOT         out  2   current slot: 0=ACT_RD, 1=REND, 2=CPU, 3=PARSE
// - REND_STB     out  1   latch strobe for Y-render / shrink registers
// - ACTRD_STB    out  1   latch strobe for active-list read register
// - PARSE_STB    out  1   latch strobe for parse register
// - PARSE_INDEX  out  9   sprite number currently being parsed
// - ACTIVE_CNT   out  7   number of active-list entries written this line
// - ACTIVE_FULL  out  1   ACTIVE_CNT==ACTIVE_MAX
// - PARSE_DONE   out  1   parse finished for this line (index overran, or list full)
// - REND_ADDR    in   11  render/shrink address supplied by the sprite pipe
// - ACTRD_ADDR   in   11  active-list read address supplied by the render side
// BEHAVIOUR
// - Reset values:
//   - phase=0, all strobes=0, CWE_n=1, CPU_BUSY=0, CPU_ACK=0.
//   - CPU_RDATA=0, PARSE_INDEX=0, ACTIVE_CNT=0, PARSE_DONE=1 (idle until the first NEW_LINE).
// - phase is a 3-bit free-running counter; SLOT = phase[2:1].
//   - Even phase = address phase; odd phase = data phase.
//   - Strobes pulse in the data phase, 1 clock, registered; data is valid on VRAM_DIN in that clock.
// - Slot 0 (ACT_RD): VRAM_ADDR = ACTRD_ADDR; ACTRD_STB at phase 1.
// - Slot 1 (REND): VRAM_ADDR = REND_ADDR; REND_STB at phase 3.
// - Slot 2 (CPU):
//   - No pending request: idle; VRAM_ADDR = CPU_ADDR register.
//   - Pending request: address from the holding register.
//   - Write: CWE_n=0 for phase 5 only.
//   - Read: VRAM_DIN captured into CPU_RDATA at end of phase 5.
//   - CPU_ACK pulses and CPU_BUSY clears in the clock after phase 5.
// - CPU holding register: one entry, loaded when CPU_REQ=1 && CPU_BUSY=0.
//   - A request accepted during phase 4 or 5 waits for the next cycle's slot 2; no partial access.
//   - Worst-case latency is 9 clocks from accept to ACK.
// - Slot 3 (PARSE) runs a 2-state FSM: PRD and AWR.
//   - PRD:
//     - VRAM_ADDR = {2'b01, PARSE_INDEX}; PARSE_STB at phase 7.
//     - PARSE_MATCH is sampled in the clock after PARSE_STB.
//     - Match and list not full: next slot 3 is AWR; index holds.
//     - Otherwise: PARSE_INDEX += 1.
//   - AWR:
//     - VRAM_ADDR = {4'b1100, ACTIVE_CNT}; VRAM_DOUT = {7'b0, PARSE_INDEX}; CWE_n=0 at phase 7.
//     - Then ACTIVE_CNT += 1, PARSE_INDEX += 1, and the FSM returns to PRD.
//   - Slot 3 is idle (no strobe, CWE_n=1) while PARSE_DONE=1.
// - PARSE_DONE sets when:
//   - PARSE_INDEX would step beyond PARSE_LAST (no wrap; index holds at PARSE_LAST), or
//   - ACTIVE_FULL becomes 1.
//   - A match seen while the list is full is dropped, not written.
// - NEW_LINE: PARSE_INDEX=0, ACTIVE_CNT=0, PARSE_DONE=0, FSM=PRD.
//   - It does not disturb phase or a pending CPU access.
//   - If NEW_LINE coincides with an AWR write clock, the write completes; the counters then clear.
// - Writes happen only at phase 5 or 7; CWE_n is never low in slots 0 and 1.
// - nRESET asserted mid-access: the access is abandoned, and CWE_n goes high asynchronously.
// STRUCTURE
// - Shared package fast_vram_pkg holds:
//   - slot encoding constants SLOT_ACT_RD, SLOT_REND, SLOT_CPU, SLOT_PARSE;
//   - base constants ACTIVE_BASE=11'h600 and YATTR_BASE=11'h200;
//   - parse FSM state typedef.
// - One sub-module, fast_vram_parse_ctl: parse FSM plus PARSE_INDEX/ACTIVE_CNT counters.
// - Top level holds the phase counter, CPU holding register and address/CWE mux.
// TESTING
// - Reset, idle: SLOT sequence 0,0,1,1,2,2,3,3 repeats; CWE_n stays 1; PARSE_DONE=1.
// - CPU write 11'h123 <= 16'hBEEF accepted at phase 0: CWE_n=0 at phase 5 with VRAM_ADDR=11'h123; ACK the next clock.
// - CPU read accepted at phase 5: serviced in the next cycle's phase 5; CPU_RDATA = model contents; BUSY is 9 clocks.
// - NEW_LINE, PARSE_MATCH=1 only for sprites 3 and 7: entries 0/1 at 11'h600/601 = 3/7; ACTIVE_CNT=2; PARSE_DONE after index 380.
// - All sprites match: exactly 96 entries written (indices 0..95); ACTIVE_FULL=1; PARSE_DONE=1; no write to 11'h660.
// - NEW_LINE during AWR, and nRESET during a CPU write: counters restart at 0; CWE_n deasserts immediately; no stray write.

Source files
------------

// File: rtl/fast_vram_pkg.sv
// Shared constants and types for the fast VRAM slot scheduler.
package fast_vram_pkg;

  localparam logic [1:0] SLOT_ACT_RD = 2'd0;
  localparam logic [1:0] SLOT_REND   = 2'd1;
  localparam logic [1:0] SLOT_CPU    = 2'd2;
  localparam logic [1:0] SLOT_PARSE  = 2'd3;

  localparam logic [10:0] ACTIVE_BASE = 11'h600;
  localparam logic [10:0] YATTR_BASE  = 11'h200;

  typedef enum logic {
    PRD = 1'b0,
    AWR = 1'b1
  } parse_state_t;

endpackage

// File: rtl/fast_vram_parse_ctl.sv
// Y-parse sequencer: walks sprite indices in slot 3 and appends matches to the active list.
module fast_vram_parse_ctl
  import fast_vram_pkg::*;
#(
  parameter int unsigned PARSE_LAST = 380,
  parameter int unsigned ACTIVE_MAX = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   phase,
  input  logic         new_line,
  input  logic         parse_match,
  output parse_state_t parse_state,
  output logic [8:0]   parse_index,
  output logic [6:0]   active_cnt,
  output logic         active_full,
  output logic         parse_done,
  output logic         parse_stb,
  output logic         parse_wr_req
);

  logic nl_pend;
  logic eval_q;
  logic line_clr;

  // A NEW_LINE landing on the slot-3 address clock is held one clock so the
  // address and data of an in-flight write stay stable until it completes.
  assign line_clr     = nl_pend | (new_line && (phase != 3'd6));
  assign active_full  = (active_cnt == 7'(ACTIVE_MAX));
  assign parse_wr_req = (parse_state == AWR) && !parse_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parse_state <= PRD;
      parse_index <= '0;
      active_cnt  <= '0;
      parse_done  <= 1'b1;
      parse_stb   <= 1'b0;
      eval_q      <= 1'b0;
      nl_pend     <= 1'b0;
    end else begin
      parse_stb <= (phase == 3'd6) && (parse_state == PRD) && !parse_done;
      nl_pend   <= new_line && (phase == 3'd6);
      if (line_clr) begin
        parse_state <= PRD;
        parse_index <= '0;
        active_cnt  <= '0;
        parse_done  <= 1'b0;
        eval_q      <= 1'b0;
      end else begin
        eval_q <= parse_stb;
        if (eval_q) begin
          if (parse_match && !active_full) begin
            parse_state <= AWR;
          end else if (parse_index == 9'(PARSE_LAST)) begin
            parse_done <= 1'b1;
          end else begin
            parse_index <= parse_index + 9'd1;
          end
        end
        if ((phase == 3'd7) && parse_wr_req) begin
          parse_state <= PRD;
          active_cnt  <= active_cnt + 7'd1;
          if (parse_index == 9'(PARSE_LAST)) begin
            parse_done <= 1'b1;
          end else begin
            parse_index <= parse_index + 9'd1;
          end
          if (active_cnt == 7'(ACTIVE_MAX - 1)) begin
            parse_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fast_vram_sched.sv
// Fast VRAM time-slot scheduler: phase counter, CPU holding register and address/CWE mux.
module fast_vram_sched
  import fast_vram_pkg::*;
#(
  parameter int unsigned PARSE_LAST = 380,
  parameter int unsigned ACTIVE_MAX = 96
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        NEW_LINE,
  input  logic        CPU_REQ,
  input  logic        CPU_WR,
  input  logic [10:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_BUSY,
  output logic [15:0] CPU_RDATA,
  output logic        CPU_ACK,
  input  logic        PARSE_MATCH,
  input  logic [15:0] VRAM_DIN,
  output logic [10:0] VRAM_ADDR,
  output logic [15:0] VRAM_DOUT,
  output logic        CWE_n,
  output logic [1:0]  SLOT,
  output logic        REND_STB,
  output logic        ACTRD_STB,
  output logic        PARSE_STB,
  output logic [8:0]  PARSE_INDEX,
  output logic [6:0]  ACTIVE_CNT,
  output logic        ACTIVE_FULL,
  output logic        PARSE_DONE,
  input  logic [10:0] REND_ADDR,
  input  logic [10:0] ACTRD_ADDR
);

  logic [2:0]   phase;
  logic [10:0]  cpu_addr_q;
  logic [15:0]  cpu_wdata_q;
  logic         cpu_wr_q;
  logic         cpu_go;
  logic         cpu_accept;
  parse_state_t parse_state;
  logic         parse_wr_req;

  assign SLOT       = phase[2:1];
  assign cpu_accept = CPU_REQ && !CPU_BUSY;

  fast_vram_parse_ctl #(
    .PARSE_LAST (PARSE_LAST),
    .ACTIVE_MAX (ACTIVE_MAX)
  ) u_parse_ctl (
    .clk          (CLK_24M),
    .rst_n        (nRESET),
    .phase        (phase),
    .new_line     (NEW_LINE),
    .parse_match  (PARSE_MATCH),
    .parse_state  (parse_state),
    .parse_index  (PARSE_INDEX),
    .active_cnt   (ACTIVE_CNT),
    .active_full  (ACTIVE_FULL),
    .parse_done   (PARSE_DONE),
    .parse_stb    (PARSE_STB),
    .parse_wr_req (parse_wr_req)
  );

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      phase       <= '0;
      ACTRD_STB   <= 1'b0;
      REND_STB    <= 1'b0;
      CWE_n       <= 1'b1;
      CPU_BUSY    <= 1'b0;
      CPU_ACK     <= 1'b0;
      CPU_RDATA   <= '0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_wr_q    <= 1'b0;
      cpu_go      <= 1'b0;
    end else begin
      phase     <= phase + 3'd1;
      ACTRD_STB <= (phase == 3'd0);
      REND_STB  <= (phase == 3'd2);
      CPU_ACK   <= 1'b0;
      if (cpu_accept) begin
        cpu_addr_q  <= CPU_ADDR;
        cpu_wdata_q <= CPU_WDATA;
        cpu_wr_q    <= CPU_WR;
        CPU_BUSY    <= 1'b1;
      end
      // Slot 2 is committed at the end of phase 3; later requests wait a full cycle.
      if (phase == 3'd3) begin
        cpu_go <= CPU_BUSY | cpu_accept;
      end
      if ((phase == 3'd5) && cpu_go) begin
        if (!cpu_wr_q) begin
          CPU_RDATA <= VRAM_DIN;
        end
        CPU_ACK  <= 1'b1;
        CPU_BUSY <= 1'b0;
        cpu_go   <= 1'b0;
      end
      CWE_n <= !(((phase == 3'd4) && cpu_go && cpu_wr_q) ||
                 ((phase == 3'd6) && parse_wr_req));
    end
  end

  always_comb begin
    VRAM_ADDR = cpu_addr_q;
    case (SLOT)
      SLOT_ACT_RD: VRAM_ADDR = ACTRD_ADDR;
      SLOT_REND:   VRAM_ADDR = REND_ADDR;
      SLOT_CPU:    VRAM_ADDR = cpu_addr_q;
      SLOT_PARSE:  VRAM_ADDR = (parse_state == AWR) ? (ACTIVE_BASE | 11'(ACTIVE_CNT))
                                                    : (YATTR_BASE | 11'(PARSE_INDEX));
    endcase
  end

  assign VRAM_DOUT = (SLOT == SLOT_PARSE) ? {7'b0, PARSE_INDEX} : cpu_wdata_q;

endmodule

// File: tb/tb_fast_vram_sched.sv
// Directed bench for fast_vram_sched with a behavioural fast-VRAM array.
module tb_fast_vram_sched;

  logic        clk;
  logic        rst_n;
  logic        new_line;
  logic        cpu_req;
  logic        cpu_wr;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        parse_match;
  logic [15:0] vram_din;
  logic [10:0] vram_addr;
  logic [15:0] vram_dout;
  logic        cwe_n;
  logic [1:0]  slot;
  logic        rend_stb;
  logic        actrd_stb;
  logic        parse_stb;
  logic [8:0]  parse_index;
  logic [6:0]  active_cnt;
  logic        active_full;
  logic        parse_done;
  logic [10:0] rend_addr;
  logic [10:0] actrd_addr;

  logic [15:0] mem [0:2047];
  logic [2:0]  ph;
  int          mode;
  int          wr_cnt;
  int          bad_phase_wr;
  int          wr_660;
  int          vectors;
  int          miscompares;

  fast_vram_sched #(
    .PARSE_LAST (380),
    .ACTIVE_MAX (96)
  ) dut (
    .CLK_24M     (clk),
    .nRESET      (rst_n),
    .NEW_LINE    (new_line),
    .CPU_REQ     (cpu_req),
    .CPU_WR      (cpu_wr),
    .CPU_ADDR    (cpu_addr),
    .CPU_WDATA   (cpu_wdata),
    .CPU_BUSY    (cpu_busy),
    .CPU_RDATA   (cpu_rdata),
    .CPU_ACK     (cpu_ack),
    .PARSE_MATCH (parse_match),
    .VRAM_DIN    (vram_din),
    .VRAM_ADDR   (vram_addr),
    .VRAM_DOUT   (vram_dout),
    .CWE_n       (cwe_n),
    .SLOT        (slot),
    .REND_STB    (rend_stb),
    .ACTRD_STB   (actrd_stb),
    .PARSE_STB   (parse_stb),
    .PARSE_INDEX (parse_index),
    .ACTIVE_CNT  (active_cnt),
    .ACTIVE_FULL (active_full),
    .PARSE_DONE  (parse_done),
    .REND_ADDR   (rend_addr),
    .ACTRD_ADDR  (actrd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference phase: position within the 8-clock cycle during the current clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 3'd0;
    else        ph <= ph + 3'd1;
  end

  assign vram_din    = mem[vram_addr];
  assign parse_match = (mode == 2) || ((mode == 1) && ((parse_index == 9'd3) || (parse_index == 9'd7)));

  always @(posedge clk) begin
    if (rst_n && (cwe_n === 1'b0)) begin
      mem[vram_addr] = vram_dout;
      wr_cnt = wr_cnt + 1;
      if ((ph != 3'd5) && (ph != 3'd7)) bad_phase_wr = bad_phase_wr + 1;
      if (vram_addr == 11'h660) wr_660 = wr_660 + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors = vectors + 1;
    assert (obs === exp_v) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n;
    n = 0;
    while ((ph != p) && (n < 16)) begin
      tick();
      n++;
    end
    chk("wait_phase", 32'(ph), 32'(p));
  endtask

  task automatic wait_parse_done(input string tag);
    int n;
    n = 0;
    while ((parse_done !== 1'b1) && (n < 6000)) begin
      tick();
      n++;
    end
    chk(tag, 32'(parse_done), 32'd1);
  endtask

  task automatic pulse_new_line();
    new_line = 1'b1;
    tick();
    new_line = 1'b0;
  endtask

  logic [1:0] slot_seq [0:7];
  int base;
  int n;
  int errs;

  initial begin
    vectors = 0; miscompares = 0;
    wr_cnt = 0; bad_phase_wr = 0; wr_660 = 0; mode = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h045] = 16'h5A3C;
    slot_seq[0] = 2'd0; slot_seq[1] = 2'd0; slot_seq[2] = 2'd1; slot_seq[3] = 2'd1;
    slot_seq[4] = 2'd2; slot_seq[5] = 2'd2; slot_seq[6] = 2'd3; slot_seq[7] = 2'd3;
    rst_n = 1'b0; new_line = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; rend_addr = 11'h2AA; actrd_addr = 11'h655;

    // Reset state
    tick(); tick();
    chk("rst_cwe_n", 32'(cwe_n), 32'd1);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_index", 32'(parse_index), 32'd0);
    chk("rst_cnt", 32'(active_cnt), 32'd0);
    chk("rst_done", 32'(parse_done), 32'd1);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_stb", {29'd0, actrd_stb, rend_stb, parse_stb}, 32'd0);
    rst_n = 1'b1;

    // Idle slot rotation and strobe placement
    for (int i = 0; i < 16; i++) begin
      chk("idle_slot", 32'(slot), 32'(slot_seq[i % 8]));
      chk("idle_actrd_stb", 32'(actrd_stb), 32'((i % 8) == 1));
      chk("idle_rend_stb", 32'(rend_stb), 32'((i % 8) == 3));
      chk("idle_parse_stb", 32'(parse_stb), 32'd0);
      chk("idle_cwe_n", 32'(cwe_n), 32'd1);
      chk("idle_addr", 32'(vram_addr), (i % 8) < 2 ? 32'h655 : ((i % 8) < 4 ? 32'h2AA : 32'(vram_addr)));
      tick();
    end
    chk("idle_done", 32'(parse_done), 32'd1);

    // CPU write accepted into phase 0
    wait_phase(3'd7);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h123; cpu_wdata = 16'hBEEF;
    tick();
    cpu_req = 1'b0;
    chk("wr_busy_set", 32'(cpu_busy), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("wr_cwe_n_ph4", 32'(cwe_n), 32'd1);
    tick();
    chk("wr_cwe_n_ph5", 32'(cwe_n), 32'd0);
    chk("wr_addr", 32'(vram_addr), 32'h123);
    chk("wr_dout", 32'(vram_dout), 32'hBEEF);
    chk("wr_ack_early", 32'(cpu_ack), 32'd0);
    tick();
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    chk("wr_busy_clr", 32'(cpu_busy), 32'd0);
    chk("wr_cwe_n_ph6", 32'(cwe_n), 32'd1);
    chk("wr_mem", 32'(mem[11'h123]), 32'hBEEF);
    tick();
    chk("wr_ack_once", 32'(cpu_ack), 32'd0);

    // CPU read seen busy from phase 5: waits for the next cycle's slot
    base = wr_cnt;
    wait_phase(3'd4);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h045; cpu_wdata = 16'h0000;
    tick();
    cpu_req = 1'b0;
    chk("rd_busy_set", 32'(cpu_busy), 32'd1);
    n = 0;
    while ((cpu_busy === 1'b1) && (n < 20)) begin
      n++;
      tick();
    end
    chk("rd_busy_len", 32'(n), 32'd9);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_data", 32'(cpu_rdata), 32'h5A3C);
    chk("rd_ack_phase", 32'(ph), 32'd6);
    chk("rd_no_write", 32'(wr_cnt - base), 32'd0);

    // Parse: sprites 3 and 7 match
    mode = 1;
    base = wr_cnt;
    wait_phase(3'd0);
    pulse_new_line();
    chk("p1_done_clr", 32'(parse_done), 32'd0);
    chk("p1_index0", 32'(parse_index), 32'd0);
    chk("p1_cnt0", 32'(active_cnt), 32'd0);
    wait_parse_done("p1_done_timeout");
    chk("p1_cnt", 32'(active_cnt), 32'd2);
    chk("p1_index_last", 32'(parse_index), 32'd380);
    chk("p1_full", 32'(active_full), 32'd0);
    chk("p1_entry0", 32'(mem[11'h600]), 32'd3);
    chk("p1_entry1", 32'(mem[11'h601]), 32'd7);
    chk("p1_writes", 32'(wr_cnt - base), 32'd2);

    // Parse: every sprite matches, list saturates at 96
    mode = 2;
    base = wr_cnt;
    wait_phase(3'd0);
    pulse_new_line();
    wait_parse_done("p2_done_timeout");
    chk("p2_cnt", 32'(active_cnt), 32'd96);
    chk("p2_full", 32'(active_full), 32'd1);
    chk("p2_index", 32'(parse_index), 32'd96);
    chk("p2_writes", 32'(wr_cnt - base), 32'd96);
    errs = 0;
    for (int i = 0; i < 96; i++) if (mem[11'h600 + i] !== 16'(i)) errs++;
    chk("p2_entries", 32'(errs), 32'd0);
    chk("p2_last_entry", 32'(mem[11'h65F]), 32'd95);
    for (int i = 0; i < 16; i++) tick();
    chk("p2_idle_after_done", 32'(wr_cnt - base), 32'd96);
    chk("p2_no_660", 32'(wr_660), 32'd0);

    // NEW_LINE coinciding with an active-list write clock
    base = wr_cnt;
    wait_phase(3'd0);
    pulse_new_line();
    n = 0;
    while (!((cwe_n === 1'b0) && (ph == 3'd7)) && (n < 40)) begin
      tick();
      n++;
    end
    chk("nl_awr_reached", 32'({cwe_n, ph}), 32'h7);
    chk("nl_awr_addr", 32'(vram_addr), 32'h600);
    new_line = 1'b1;
    tick();
    new_line = 1'b0;
    mode = 0;
    chk("nl_write_done", 32'(wr_cnt - base), 32'd1);
    chk("nl_cnt", 32'(active_cnt), 32'd0);
    chk("nl_index", 32'(parse_index), 32'd0);
    chk("nl_done", 32'(parse_done), 32'd0);
    chk("nl_cwe_n", 32'(cwe_n), 32'd1);

    // nRESET in the middle of a CPU write
    wait_phase(3'd7);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h077; cpu_wdata = 16'h1234;
    tick();
    cpu_req = 1'b0;
    base = wr_cnt;
    wait_phase(3'd5);
    chk("rst_mid_cwe_low", 32'(cwe_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cwe_high", 32'(cwe_n), 32'd1);
    chk("rst_mid_busy", 32'(cpu_busy), 32'd0);
    chk("rst_mid_done", 32'(parse_done), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_mid_no_write", 32'(wr_cnt - base), 32'd0);
    chk("rst_mid_mem", 32'(mem[11'h077]), 32'd0);
    chk("rst_mid_index", 32'(parse_index), 32'd0);
    chk("rst_mid_cnt", 32'(active_cnt), 32'd0);
    chk("rst_mid_slot", 32'(slot), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("rst_mid_still_idle", 32'(wr_cnt - base), 32'd0);

    chk("write_phase_violations", 32'(bad_phase_wr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
